// File: rtl/pwm_peripheral.sv
// 16-pin PWM output stage: prescaled 8-bit period counter, double-buffered duty,
// and per-pin force-low / force-high / PWM selection with registered pin drive.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 3000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] out_7_0,
  output logic [7:0] out_15_8,
  output logic       period_start
);

  localparam int unsigned PRESC_W = 16;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned PIN_N   = 16;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = {CNT_W{1'b1}};

  logic [PRESC_W-1:0] prescaler;
  logic [CNT_W-1:0]   pwm_cnt;
  logic [CNT_W-1:0]   duty_shadow;
  logic [PIN_N-1:0]   pins_q;

  logic               tick_c;
  logic               wrap_c;
  logic               pwm_raw_c;
  logic [PIN_N-1:0]   en_out_c;
  logic [PIN_N-1:0]   en_pwm_c;
  logic [PIN_N-1:0]   pins_next_c;

  // Full-scale duty is a special case so 0xFF means a solid high level.
  always_comb begin
    tick_c    = (prescaler == PRESC_LAST);
    wrap_c    = tick_c && (pwm_cnt == CNT_LAST);
    pwm_raw_c = (duty_shadow == CNT_LAST) || (pwm_cnt < duty_shadow);
  end

  assign en_out_c    = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm_c    = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign pins_next_c = en_out_c & (~en_pwm_c | {PIN_N{pwm_raw_c}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
    end else if (tick_c) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else if (tick_c) begin
      pwm_cnt <= pwm_cnt + CNT_W'(1);
    end
  end

  // Duty only moves at the period boundary, so a running period is never cut short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_shadow  <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap_c;
      if (wrap_c) begin
        duty_shadow <= pwm_duty_cycle;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pins_q <= '0;
    end else begin
      pins_q <= pins_next_c;
    end
  end

  assign out_7_0  = pins_q[7:0];
  assign out_15_8 = pins_q[15:8];

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: CLK_DIV=1 and CLK_DIV=4 instances on shared inputs,
// checked every cycle against a cycle-count model plus directed period measurements.
module tb_pwm_peripheral;

  logic        clk;
  logic        rst;
  logic [15:0] en_out16;
  logic [15:0] en_pwm16;
  logic [7:0]  duty;

  logic [7:0]  out1_lo, out1_hi, out4_lo, out4_hi;
  logic        ps1, ps4;

  int checks   = 0;
  int failures = 0;

  pwm_peripheral #(.CLK_DIV(1)) u_div1 (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_out16[7:0]),
    .en_reg_out_15_8 (en_out16[15:8]),
    .en_reg_pwm_7_0  (en_pwm16[7:0]),
    .en_reg_pwm_15_8 (en_pwm16[15:8]),
    .pwm_duty_cycle  (duty),
    .out_7_0         (out1_lo),
    .out_15_8        (out1_hi),
    .period_start    (ps1)
  );

  pwm_peripheral #(.CLK_DIV(4)) u_div4 (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_out16[7:0]),
    .en_reg_out_15_8 (en_out16[15:8]),
    .en_reg_pwm_7_0  (en_pwm16[7:0]),
    .en_reg_pwm_15_8 (en_pwm16[15:8]),
    .pwm_duty_cycle  (duty),
    .out_7_0         (out4_lo),
    .out_15_8        (out4_hi),
    .period_start    (ps4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int unsigned div_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  // Level of the shared waveform at a given count step within the period.
  function automatic logic level(input int unsigned step, input logic [7:0] sh);
    return (sh == 8'hFF) || (step < 32'(sh));
  endfunction

  function automatic logic [15:0] exp_pins(input logic [15:0] eo, input logic [15:0] ep,
                                           input logic raw);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = eo[i] ? (ep[i] ? raw : 1'b1) : 1'b0;
    return r;
  endfunction

  // Model: position in the period is (clocks since reset) mod 256*CLK_DIV.
  int unsigned m_c    [2];
  logic [7:0]  m_sh   [2];
  logic [15:0] m_pins [2];
  logic        m_ps   [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_c[k]    <= 0;
        m_sh[k]   <= 8'h00;
        m_pins[k] <= 16'h0000;
        m_ps[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_pins[k] <= exp_pins(en_out16, en_pwm16, level(m_c[k] / div_of(k), m_sh[k]));
        m_ps[k]   <= (m_c[k] == 256 * div_of(k) - 1);
        if (m_c[k] == 256 * div_of(k) - 1) m_sh[k] <= duty;
        m_c[k]    <= (m_c[k] + 1) % (256 * div_of(k));
      end
    end
  end

  always @(negedge clk) begin
    check("div1_pins", 32'({out1_hi, out1_lo}), 32'(m_pins[0]));
    check("div1_period_start", 32'(ps1), 32'(m_ps[0]));
    check("div4_pins", 32'({out4_hi, out4_lo}), 32'(m_pins[1]));
    check("div4_period_start", 32'(ps4), 32'(m_ps[1]));
  end

  task automatic wait_ps(input int which, input int limit, input string name, input int exp_n);
    int   n    = 0;
    logic seen = 1'b0;
    while (!seen && n < limit) begin
      @(negedge clk);
      n++;
      seen = ((which == 0) ? ps1 : ps4) === 1'b1;
    end
    check({name, "_seen"}, 32'(seen), 32'd1);
    if (exp_n > 0) check(name, 32'(n), 32'(exp_n));
  endtask

  task automatic measure(input int which, input int n, output int high, output int rises);
    logic prev, cur;
    high  = 0;
    rises = 0;
    prev  = (which == 0) ? out1_lo[0] : out4_lo[0];
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cur = (which == 0) ? out1_lo[0] : out4_lo[0];
      if (cur) high++;
      if (cur && !prev) rises++;
      prev = cur;
    end
  endtask

  initial begin
    int hi, ri;
    logic cur, prev;

    en_out16 = 16'hFFFF;
    en_pwm16 = 16'hFFFF;
    duty     = 8'h80;
    rst      = 1'b0;
    #1 rst   = 1'b1;

    // Reset holds every pin low even with all enables set.
    repeat (3) @(negedge clk);
    check("rst_out_7_0", 32'(out1_lo), 32'h00);
    check("rst_out_15_8", 32'(out1_hi), 32'h00);
    check("rst_period_start", 32'(ps1), 32'h0);
    check("rst_div4_pins", 32'({out4_hi, out4_lo}), 32'h0000);
    rst = 1'b0;
    wait_ps(0, 300, "first_ps_latency", 256);

    // Static drive and force-low regardless of PWM select.
    en_out16 = 16'h0081;
    en_pwm16 = 16'hFF00;
    @(negedge clk);
    check("static_lo_next", 32'(out1_lo), 32'h81);
    check("static_hi_low", 32'(out1_hi), 32'h00);
    repeat (20) @(negedge clk);
    check("static_lo_held", 32'(out1_lo), 32'h81);
    check("static_hi_held", 32'(out1_hi), 32'h00);
    check("static_div4_lo", 32'(out4_lo), 32'h81);

    // 50% duty on pin 0.
    en_out16 = 16'h0001;
    en_pwm16 = 16'h0001;
    wait_ps(0, 300, "ps_before_50", 0);
    measure(0, 256, hi, ri);
    check("duty80_high", 32'(hi), 32'd128);
    check("duty80_rises", 32'(ri), 32'd1);
    check("duty80_period_end", 32'(ps1), 32'd1);
    measure(0, 256, hi, ri);
    check("duty80_high_2", 32'(hi), 32'd128);

    // Full scale stays high across three periods.
    duty = 8'hFF;
    wait_ps(0, 300, "ps_to_ff", 256);
    measure(0, 768, hi, ri);
    check("dutyff_high", 32'(hi), 32'd768);
    check("dutyff_rises", 32'(ri), 32'd1);

    duty = 8'h00;
    wait_ps(0, 300, "ps_to_00", 256);
    measure(0, 768, hi, ri);
    check("duty00_high", 32'(hi), 32'd0);

    // Duty present only in the wrap cycle is still captured.
    repeat (255) @(negedge clk);
    duty = 8'h40;
    wait_ps(0, 3, "wrap_write_ps", 1);
    duty = 8'h10;
    measure(0, 256, hi, ri);
    check("wrap_write_high", 32'(hi), 32'd64);
    duty = 8'h40;
    measure(0, 256, hi, ri);
    check("duty10_high", 32'(hi), 32'd16);

    // Mid-period write waits for the next boundary.
    hi   = 0;
    ri   = 0;
    prev = out1_lo[0];
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      cur = out1_lo[0];
      if (cur) hi++;
      if (cur && !prev) ri++;
      prev = cur;
      if (i == 16) duty = 8'hC0;
    end
    check("shadow_cur_high", 32'(hi), 32'd64);
    check("shadow_cur_rises", 32'(ri), 32'd1);
    check("shadow_boundary", 32'(ps1), 32'd1);
    measure(0, 256, hi, ri);
    check("shadow_next_high", 32'(hi), 32'd192);
    check("shadow_next_rises", 32'(ri), 32'd1);

    // Prescaled instance: period and 50% width.
    duty = 8'h80;
    wait_ps(1, 1100, "div4_sync", 0);
    wait_ps(1, 1100, "div4_period", 1024);
    measure(1, 1024, hi, ri);
    check("div4_high", 32'(hi), 32'd512);
    check("div4_rises", 32'(ri), 32'd1);

    // Asynchronous reset at pwm_cnt 0x30 clears outputs without waiting for a clock.
    repeat (192) @(negedge clk);
    check("div4_mid_high", 32'(out4_lo), 32'h01);
    #1 rst = 1'b1;
    #1;
    check("async_rst_div4", 32'({out4_hi, out4_lo}), 32'h0000);
    check("async_rst_div1", 32'({out1_hi, out1_lo}), 32'h0000);
    check("async_rst_ps", 32'({ps1, ps4}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_ps(1, 1100, "div4_after_rst", 1024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
